// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter
// Round-robin arbiter sharing one bitwise logic unit between NUM_REQ
// requesters. The winning request is evaluated combinationally and captured
// into a single registered response slot, tagged with the requester index.
// The slot reloads in the same cycle it drains, so the unit sustains one
// result per cycle while the consumer is ready.
module logic_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*3-1:0]     req_op_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     rsp_err_o,
  output logic [15:0]              done_cnt_o
);

  localparam logic [2:0] OP_ENABLE = 3'd0;
  localparam logic [2:0] OP_INVERT = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] alu_data;
  logic             alu_err;

  // The slot can take a new result if it is empty or being emptied right now.
  assign slot_free = !rsp_valid_o || rsp_ready_i;

  // Search requesters starting at ptr and wrapping; the first valid one wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Reset gates the grant so nothing is accepted while the block is held.
  assign accept = !rst_i && slot_free && found;

  // One-hot grant and operand selection for the winning requester.
  always_comb begin
    req_ready_o = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_op      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        req_ready_o[k] = accept;
        sel_a          = req_a_i[k*WIDTH +: WIDTH];
        sel_b          = req_b_i[k*WIDTH +: WIDTH];
        sel_op         = req_op_i[k*3 +: 3];
      end
    end
  end

  // Shared bitwise unit; ENABLE/AND and INVERT/XOR are the same gate function.
  always_comb begin
    alu_data = '0;
    alu_err  = 1'b0;
    case (sel_op)
      OP_ENABLE: alu_data = sel_a & sel_b;
      OP_INVERT: alu_data = sel_a ^ sel_b;
      OP_AND:    alu_data = sel_a & sel_b;
      OP_OR:     alu_data = sel_a | sel_b;
      OP_XOR:    alu_data = sel_a ^ sel_b;
      default: begin
        alu_data = '0;
        alu_err  = 1'b1;
      end
    endcase
  end

  // Pointer moves just past the winner, wrapping the last requester to 0.
  assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

  // Response slot and round-robin pointer; data/id/err hold after a drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
      rsp_err_o   <= 1'b0;
      ptr         <= '0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= alu_data;
      rsp_id_o    <= winner;
      rsp_err_o   <= alu_err;
      ptr         <= ptr_next;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  // Saturating count of responses handed to the consumer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_cnt_o <= '0;
    end else if (rsp_valid_o && rsp_ready_i && (done_cnt_o != 16'hFFFF)) begin
      done_cnt_o <= done_cnt_o + 16'd1;
    end
  end

endmodule
